// File: rtl/dt_pkg.sv
// Shared types and helpers for the dt_two_pass chamfer distance transform.
// The B_* states exist only when DT_BACKWARD_EN is defined.
package dt_pkg;

    localparam int unsigned DIST_W_DEF = 8;
    localparam int unsigned DIST_MAX   = (1 << DIST_W_DEF) - 1;

    typedef enum logic [2:0] {
        F_CHK,
        F_RD,
        F_WR,
`ifdef DT_BACKWARD_EN
        B_CHK,
        B_RD,
        B_WR,
`endif
        S_DONE
    } state_e;

    // Forward pass order: NW, N, NE, W.  Backward pass order: E, SW, S, SE.
    typedef enum logic [1:0] {NB_0, NB_1, NB_2, NB_3} nb_e;

    function automatic int unsigned sat_inc(input int unsigned x,
                                            input int unsigned max_v = DIST_MAX);
        return (x >= max_v) ? max_v : x + 1;
    endfunction

endpackage

// File: rtl/dt_min4.sv
// Unsigned minimum of four distance values, built as a two-level compare tree.
module dt_min4
    import dt_pkg::*;
#(
    parameter int unsigned DIST_W = DIST_W_DEF
) (
    input  logic [DIST_W-1:0] a,
    input  logic [DIST_W-1:0] b,
    input  logic [DIST_W-1:0] c,
    input  logic [DIST_W-1:0] d,
    output logic [DIST_W-1:0] y
);

    logic [DIST_W-1:0] ab;
    logic [DIST_W-1:0] cd;

    always_comb begin
        ab = (a < b) ? a : b;
        cd = (c < d) ? c : d;
        y  = (ab < cd) ? ab : cd;
    end

endmodule

// File: rtl/dt_two_pass.sv
// Two-pass chamfer distance transform between the STI ROM and the RES RAM.
// Define DT_BACKWARD_EN to compile the reverse-raster refinement pass.
module dt_two_pass
    import dt_pkg::*;
#(
    parameter int unsigned IMG_W  = 128,
    parameter int unsigned IMG_H  = 128,
    parameter int unsigned STI_W  = 16,
    parameter int unsigned DIST_W = DIST_W_DEF,
    parameter int unsigned STI_AW = 10,
    parameter int unsigned RES_AW = 14
) (
    input  logic              clk,
    input  logic              reset,
    output logic              done,
    output logic              sti_rd,
    output logic [STI_AW-1:0] sti_addr,
    input  logic [STI_W-1:0]  sti_di,
    output logic              res_wr,
    output logic              res_rd,
    output logic [RES_AW-1:0] res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di
);

    localparam int unsigned       CB   = $clog2(IMG_W);
    localparam int unsigned       SB   = $clog2(STI_W);
    localparam int unsigned       DMAX = (1 << DIST_W) - 1;
    localparam logic [RES_AW-1:0] LAST = RES_AW'(IMG_W * IMG_H - 1);
    localparam logic [RES_AW-1:0] ROW  = RES_AW'(IMG_W);
    localparam logic [RES_AW-1:0] ONE  = RES_AW'(1);

    state_e            state, state_nxt;
    nb_e               nb;
    logic [RES_AW-1:0] p, nb_addr, row;
    logic [CB-1:0]     col;
    logic [SB-1:0]     bit_sel;
    logic              border, obj_now, obj;
    logic [DIST_W-1:0] nbr [4];
    logic [DIST_W-1:0] min4, inc;
`ifdef DT_BACKWARD_EN
    logic [DIST_W-1:0] d;
`endif

    dt_min4 #(.DIST_W(DIST_W)) u_min4 (
        .a (nbr[0]),
        .b (nbr[1]),
        .c (nbr[2]),
        .d (nbr[3]),
        .y (min4)
    );

    always_comb begin
        row     = p >> CB;
        col     = p[CB-1:0];
        bit_sel = p[SB-1:0];
        border  = (row == '0) || (row == RES_AW'(IMG_H - 1)) || (col == '0) || (col == '1);
        obj_now = sti_di[~bit_sel] && !border;
        inc     = DIST_W'(sat_inc(32'(min4), DMAX));
    end

    always_comb begin
        nb_addr = p;
        if (state == F_RD) begin
            case (nb)
                NB_0: nb_addr = p - ROW - ONE;
                NB_1: nb_addr = p - ROW;
                NB_2: nb_addr = p - ROW + ONE;
                NB_3: nb_addr = p - ONE;
            endcase
        end
`ifdef DT_BACKWARD_EN
        else if (state == B_RD) begin
            case (nb)
                NB_0: nb_addr = p + ONE;
                NB_1: nb_addr = p + ROW - ONE;
                NB_2: nb_addr = p + ROW;
                NB_3: nb_addr = p + ROW + ONE;
            endcase
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= F_CHK;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            F_CHK: state_nxt = obj_now ? F_RD : F_WR;
            F_RD:  if (nb == NB_3) state_nxt = F_WR;
            F_WR: begin
                if (p != LAST) state_nxt = F_CHK;
`ifdef DT_BACKWARD_EN
                else           state_nxt = B_CHK;
`else
                else           state_nxt = S_DONE;
`endif
            end
`ifdef DT_BACKWARD_EN
            B_CHK: begin
                if (res_di != '0)  state_nxt = B_RD;
                else if (p == '0) state_nxt = S_DONE;
            end
            B_RD:  if (nb == NB_3) state_nxt = B_WR;
            B_WR:  state_nxt = (p == '0) ? S_DONE : B_CHK;
`endif
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = F_CHK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p   <= '0;
            nb  <= NB_0;
            obj <= 1'b0;
            nbr <= '{default: '0};
`ifdef DT_BACKWARD_EN
            d   <= '0;
`endif
        end else begin
            case (state)
                F_CHK: obj <= obj_now;
                F_RD: begin
                    nbr[nb] <= res_di;
                    nb      <= nb_e'(nb + 2'd1);
                end
                F_WR: if (p != LAST) p <= p + ONE;
`ifdef DT_BACKWARD_EN
                B_CHK: begin
                    d <= res_di;
                    if (res_di == '0 && p != '0) p <= p - ONE;
                end
                B_RD: begin
                    nbr[nb] <= res_di;
                    nb      <= nb_e'(nb + 2'd1);
                end
                B_WR: if (p != '0) p <= p - ONE;
`endif
                default: ;
            endcase
        end
    end

    // Outputs are gated by reset so they read 0 throughout reset even though the FSM rests in F_CHK.
    always_comb begin
        done     = 1'b0;
        sti_rd   = 1'b0;
        sti_addr = '0;
        res_wr   = 1'b0;
        res_rd   = 1'b0;
        res_addr = '0;
        res_do   = '0;
        if (!reset) begin
            case (state)
                F_CHK: begin
                    sti_rd   = 1'b1;
                    sti_addr = STI_AW'(p >> SB);
                end
                F_RD: begin
                    res_rd   = 1'b1;
                    res_addr = nb_addr;
                end
                F_WR: begin
                    res_wr   = 1'b1;
                    res_addr = p;
                    res_do   = obj ? inc : '0;
                end
`ifdef DT_BACKWARD_EN
                B_CHK: begin
                    res_rd   = 1'b1;
                    res_addr = p;
                end
                B_RD: begin
                    res_rd   = 1'b1;
                    res_addr = nb_addr;
                end
                B_WR: begin
                    res_wr   = 1'b1;
                    res_addr = p;
                    res_do   = (d < inc) ? d : inc;
                end
`endif
                S_DONE:  done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dt_two_pass.sv
// Directed bench for dt_two_pass on a 16x16 image: an 8-bit and a 2-bit distance instance
// share one STI image; each has its own RES RAM. Honors DT_BACKWARD_EN.
module tb_dt_two_pass;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;
`ifdef DT_BACKWARD_EN
    localparam bit BWD = 1'b1;
`else
    localparam bit BWD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic img [N];

    logic        done_w, sti_rd_w, res_wr_w, res_rd_w;
    logic [3:0]  sti_addr_w;
    logic [15:0] sti_di_w;
    logic [7:0]  res_addr_w, res_do_w, res_di_w;
    logic        done_n, sti_rd_n, res_wr_n, res_rd_n;
    logic [3:0]  sti_addr_n;
    logic [15:0] sti_di_n;
    logic [7:0]  res_addr_n;
    logic [1:0]  res_do_n, res_di_n;

    logic [7:0] ram_w [N];
    logic [1:0] ram_n [N];

    dt_two_pass #(.IMG_W(W), .IMG_H(H), .STI_W(16), .DIST_W(8), .STI_AW(4), .RES_AW(8)) dut_w (
        .clk(clk), .reset(reset), .done(done_w), .sti_rd(sti_rd_w), .sti_addr(sti_addr_w),
        .sti_di(sti_di_w), .res_wr(res_wr_w), .res_rd(res_rd_w), .res_addr(res_addr_w),
        .res_do(res_do_w), .res_di(res_di_w));

    dt_two_pass #(.IMG_W(W), .IMG_H(H), .STI_W(16), .DIST_W(2), .STI_AW(4), .RES_AW(8)) dut_n (
        .clk(clk), .reset(reset), .done(done_n), .sti_rd(sti_rd_n), .sti_addr(sti_addr_n),
        .sti_di(sti_di_n), .res_wr(res_wr_n), .res_rd(res_rd_n), .res_addr(res_addr_n),
        .res_do(res_do_n), .res_di(res_di_n));

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            sti_di_w[15-k] = img[int'(sti_addr_w) * 16 + k];
            sti_di_n[15-k] = img[int'(sti_addr_n) * 16 + k];
        end
    end

    assign res_di_w = ram_w[res_addr_w];
    assign res_di_n = ram_n[res_addr_n];
    always @(posedge clk) begin
        if (res_wr_w) ram_w[res_addr_w] <= res_do_w;
        if (res_wr_n) ram_n[res_addr_n] <= res_do_n;
    end

    // Bus monitor, sampled on the falling edge; cleared while reset is high.
    int overlap, bad_rd, first_wr;
    bit seen_w [N];
    bit seen_n [N];
    int wr_cnt [N];
    always @(negedge clk) begin
        if (reset) begin
            overlap  = 0;
            bad_rd   = 0;
            first_wr = -1;
            for (int i = 0; i < N; i++) begin
                seen_w[i] = 1'b0;
                seen_n[i] = 1'b0;
                wr_cnt[i] = 0;
            end
        end else begin
            if (res_rd_w && res_wr_w) overlap++;
            if (res_rd_n && res_wr_n) overlap++;
            if (res_rd_w && !seen_w[res_addr_w]) bad_rd++;
            if (res_rd_n && !seen_n[res_addr_n]) bad_rd++;
            if (res_wr_w) begin
                if (first_wr < 0) first_wr = int'(res_addr_w);
                seen_w[res_addr_w] = 1'b1;
                wr_cnt[res_addr_w]++;
            end
            if (res_wr_n) seen_n[res_addr_n] = 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        int tst;
        int row;
        int col;
        int fw;
        int bw;
        int fn;
        int bn;
    } vec_t;

    vec_t vecs [32];
    int   nv = 0;

    task automatic add(input int t, input int r, input int c,
                       input int fw, input int bw, input int fn, input int bn);
        vecs[nv] = '{t, r, c, fw, bw, fn, bn};
        nv++;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit is_obj(input int p);
        int r, c;
        r = p / W;
        c = p % W;
        return img[p] && r > 0 && r < H - 1 && c > 0 && c < W - 1;
    endfunction

    int gold [2][N];

    task automatic build_golden();
        int maxv, m;
        for (int k = 0; k < 2; k++) begin
            maxv = (k == 0) ? 255 : 3;
            for (int p = 0; p < N; p++) begin
                if (is_obj(p)) begin
                    m = imin(imin(gold[k][p-W-1], gold[k][p-W]), imin(gold[k][p-W+1], gold[k][p-1]));
                    gold[k][p] = imin(m + 1, maxv);
                end else begin
                    gold[k][p] = 0;
                end
            end
            if (BWD) begin
                for (int p = N - 1; p >= 0; p--) begin
                    if (gold[k][p] != 0) begin
                        m = imin(imin(gold[k][p+1], gold[k][p+W-1]), imin(gold[k][p+W], gold[k][p+W+1]));
                        gold[k][p] = imin(gold[k][p], imin(m + 1, maxv));
                    end
                end
            end
        end
    endtask

    function automatic int expected_cycles();
        int n;
        n = 0;
        for (int p = 0; p < N; p++) begin
            n += is_obj(p) ? 6 : 2;
            if (BWD) n += is_obj(p) ? 6 : 1;
        end
        return n;
    endfunction

    task automatic clear_img();
        for (int i = 0; i < N; i++) img[i] = 1'b0;
    endtask

    task automatic set_block(input int r0, input int r1, input int c0, input int c1);
        for (int r = r0; r <= r1; r++)
            for (int c = c0; c <= c1; c++)
                img[r*W + c] = 1'b1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int t, output int cycles);
        cycles = 0;
        while (!(done_w && done_n) && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check($sformatf("t%0d_done", t), int'(done_w && done_n), 1);
    endtask

    task automatic post_checks(input int t, input int cycles);
        int mw, mn, idx;
        build_golden();
        check($sformatf("t%0d_cycles", t), cycles, expected_cycles());
        check($sformatf("t%0d_rd_wr_overlap", t), overlap, 0);
        check($sformatf("t%0d_rd_unwritten", t), bad_rd, 0);
        check($sformatf("t%0d_first_wr_addr", t), first_wr, 0);
        mw = 0;
        mn = 0;
        for (int i = 0; i < N; i++) begin
            if (int'(ram_w[i]) != gold[0][i]) mw++;
            if (int'(ram_n[i]) != gold[1][i]) mn++;
        end
        check($sformatf("t%0d_ram_w_mismatches", t), mw, 0);
        check($sformatf("t%0d_ram_n_mismatches", t), mn, 0);
        for (int i = 0; i < nv; i++) begin
            if (vecs[i].tst == t) begin
                idx = vecs[i].row * W + vecs[i].col;
                check($sformatf("t%0d_w_r%0dc%0d", t, vecs[i].row, vecs[i].col),
                      int'(ram_w[idx]), BWD ? vecs[i].bw : vecs[i].fw);
                check($sformatf("t%0d_n_r%0dc%0d", t, vecs[i].row, vecs[i].col),
                      int'(ram_n[idx]), BWD ? vecs[i].bn : vecs[i].fn);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, cnt, found;

        for (int i = 0; i < N; i++) begin
            ram_w[i] = '0;
            ram_n[i] = '0;
        end

        //   test row col  fwd8 bwd8 fwd2 bwd2
        add(1,  0,  0,   0, 0, 0, 0);
        add(1,  8,  8,   0, 0, 0, 0);
        add(2,  5,  5,   1, 1, 1, 1);
        add(2,  5,  6,   0, 0, 0, 0);
        add(2,  6,  6,   0, 0, 0, 0);
        add(3, 14, 14,   1, 1, 1, 1);
        add(3, 12, 12,   3, 3, 3, 3);
        add(3, 14, 12,   3, 1, 3, 1);
        add(3, 13, 12,   3, 2, 3, 2);
        add(3, 13, 13,   2, 2, 2, 2);
        add(3, 10, 10,   1, 1, 1, 1);
        add(3, 11, 12,   2, 2, 2, 2);
        add(4,  0,  7,   0, 0, 0, 0);
        add(4,  4, 15,   0, 0, 0, 0);
        add(4, 15,  3,   0, 0, 0, 0);
        add(4,  4,  0,   0, 0, 0, 0);
        add(5,  7,  7,   5, 5, 3, 3);
        add(5, 12,  7,   5, 1, 3, 1);
        add(5,  4,  4,   2, 2, 2, 2);
        add(5,  8, 10,   3, 3, 3, 3);
        add(5,  3,  3,   1, 1, 1, 1);
        add(5, 12, 12,   1, 1, 1, 1);
        add(6,  7,  7,   5, 5, 3, 3);

        // Reset state: every output low while reset is held.
        clear_img();
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'(|{done_w, sti_rd_w, res_wr_w, res_rd_w, sti_addr_w, res_addr_w,
                                       res_do_w, done_n, sti_rd_n, res_wr_n, res_rd_n, sti_addr_n,
                                       res_addr_n, res_do_n}), 0);

        // 1: all background.
        apply_reset();
        wait_done(1, cyc);
        check("t1_done_cycle", cyc, BWD ? 3 * N : 2 * N);
        cnt = 0;
        for (int i = 0; i < N; i++) if (wr_cnt[i] != 1) cnt++;
        check("t1_addr_not_written_once", cnt, 0);
        post_checks(1, cyc);

        // 2: single object pixel.
        clear_img();
        img[5*W + 5] = 1'b1;
        apply_reset();
        wait_done(2, cyc);
        post_checks(2, cyc);

        // 3: 5x5 block.
        clear_img();
        set_block(10, 14, 10, 14);
        apply_reset();
        wait_done(3, cyc);
        post_checks(3, cyc);

        // 4: objects only on border pixels.
        clear_img();
        img[0*W + 7]  = 1'b1;
        img[15*W + 3] = 1'b1;
        img[4*W + 0]  = 1'b1;
        img[4*W + 15] = 1'b1;
        apply_reset();
        wait_done(4, cyc);
        post_checks(4, cyc);

        // 5: 10x10 block; the 2-bit instance must clamp at 3 and never wrap.
        clear_img();
        set_block(3, 12, 3, 12);
        apply_reset();
        wait_done(5, cyc);
        post_checks(5, cyc);
        cnt = 0;
        for (int i = 0; i < N; i++) if (is_obj(i) && ram_n[i] == 2'd0) cnt++;
        check("t5_narrow_wrapped_to_zero", cnt, 0);

        // 6: reset asserted mid forward pass, then a full rerun.
        apply_reset();
        found = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            @(negedge clk);
            if (res_wr_w && res_addr_w == 8'd100) found = 1;
        end
        check("t6_reached_p100", found, 1);
        reset = 1'b1;
        #1;
        check("t6_outputs_in_reset", int'(|{done_w, sti_rd_w, res_wr_w, res_rd_w, sti_addr_w, res_addr_w,
                                           res_do_w, done_n, sti_rd_n, res_wr_n, res_rd_n, sti_addr_n,
                                           res_addr_n, res_do_n}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t6_restart_sti_rd", int'(sti_rd_w), 1);
        check("t6_restart_sti_addr", int'(sti_addr_w), 0);
        wait_done(6, cyc);
        post_checks(6, cyc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
